// File: rtl/multi_drive_resolver.sv
// multi_drive_resolver: per-bit resolution of N tri-state drivers into data/z/x masks, buffered in a 2-entry FIFO
// Ports: clk, rst (async, active-high); in_valid/in_ready with drv_data/drv_en/mode (driver set);
//        out_valid/out_ready with res_data/res_zmask/res_xmask (resolved word);
//        conflict_cnt/err_sticky (strict-mode conflict statistics), clr_err (sync clear).
module multi_drive_resolver #(
    parameter int W = 12,
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0][W-1:0] drv_data,
    input  logic [N-1:0][W-1:0] drv_en,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       res_data,
    output logic [W-1:0]       res_zmask,
    output logic [W-1:0]       res_xmask,
    output logic [7:0]         conflict_cnt,
    output logic               err_sticky,
    input  logic               clr_err
);
    // one_v: some enabled driver drives 1; zero_v: some enabled driver drives 0
    logic [W-1:0] one_v, zero_v, any_v, d_v, x_v;
    logic [3*W-1:0] mem [2];
    logic [1:0] occ;
    logic wp, rp, push, pop;
    always_comb begin
        one_v  = '0;
        zero_v = '0;
        for (int i = 0; i < N; i++) begin
            one_v  = one_v | (drv_en[i] & drv_data[i]);
            zero_v = zero_v | (drv_en[i] & ~drv_data[i]);
        end
        any_v = one_v | zero_v;
        d_v   = mode == 2'd1 ? one_v : mode == 2'd2 ? (any_v & ~zero_v) : (one_v & ~zero_v);
        x_v   = (mode == 2'd1 || mode == 2'd2) ? '0 : (one_v & zero_v);
    end
    assign in_ready  = !rst && !occ[1];
    assign out_valid = occ != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {res_data, res_zmask, res_xmask} = out_valid ? mem[rp] : '0;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {d_v, ~any_v, x_v};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ          <= '0;
            wp           <= 1'b0;
            rp           <= 1'b0;
            conflict_cnt <= '0;
            err_sticky   <= 1'b0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            // a clear coinciding with a conflicting word clears first, then counts it
            if (push && |x_v) begin
                conflict_cnt <= clr_err ? 8'd1 : conflict_cnt == 8'hFF ? conflict_cnt : conflict_cnt + 8'd1;
                err_sticky   <= 1'b1;
            end else if (clr_err) begin
                conflict_cnt <= '0;
                err_sticky   <= 1'b0;
            end
        end
    end
endmodule
